mult_sequencer: RTL and testbench

- Controller that sequences the 32-bit shift-add unsigned multiplier (Multiplier: 6-bit Signal opcode, active-high reset loads operands, 64-bit dataOut).
- Accepts a start/operand request, loads the multiplier, issues exactly the required MULTU steps, captures the 64-bit product into HI/LO registers, and pulses done.
- Sits between the ALU/CPU control path and the multiplier datapath.

---
 rtl/mult_sequencer.sv | 91 +++++++++
 tb/tb_mult_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: drives a shift-add multiplier through load, WIDTH MULTU steps and capture into hi/lo.
// Optional MULT_EARLY_EXIT_EN stops stepping once the remaining multiplier bits are all zero.
module mult_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [5:0]  OP_MULTU = 6'b011001,
    parameter logic [5:0]  OP_NOP   = 6'b000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    output logic                 mul_reset,
    output logic [5:0]           mul_signal,
    output logic [WIDTH-1:0]     mul_data_a,
    output logic [WIDTH-1:0]     mul_data_b,
    input  logic [2*WIDTH-1:0]   mul_product
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;
    state_t state, state_d;
    logic [CW-1:0] counter;
    logic [WIDTH-1:0] a_q, b_q;
    logic last_step;
`ifdef MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0] shadow;
    assign last_step = (shadow >> 1) == '0 || counter == CW'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (!reset)
            shadow <= '0;
        else if (state == LOAD)
            shadow <= b_q;
        else if (state == RUN)
            shadow <= shadow >> 1;
    end
`else
    assign last_step = counter == CW'(WIDTH - 1);
`endif
    assign busy       = state != IDLE;
    assign mul_data_a = a_q;
    assign mul_data_b = b_q;
    always_comb begin
        state_d    = state;
        mul_reset  = !reset;
        mul_signal = OP_NOP;
        unique case (state)
            IDLE: state_d = start ? LOAD : IDLE;
            LOAD: begin
                mul_reset = 1'b1;
`ifdef MULT_EARLY_EXIT_EN
                state_d = b_q == '0 ? CAPT : RUN;
`else
                state_d = RUN;
`endif
            end
            RUN: begin
                mul_signal = OP_MULTU;
                state_d    = last_step ? CAPT : RUN;
            end
            CAPT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            done    <= state == CAPT;
            counter <= state == RUN ? counter + 1'b1 : '0;
            if (state == IDLE && start) begin
                a_q <= op_a;
                b_q <= op_b;
            end
            if (state == CAPT) begin
                hi <= mul_product[2*WIDTH-1:WIDTH];
                lo <= mul_product[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: scoreboard bench with a behavioural shift-add multiplier attached to the sequencer.
module tb_mult_sequencer;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_NOP   = 6'b000000;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic busy, done, mul_reset;
    logic [31:0] hi, lo, mul_data_a, mul_data_b;
    logic [5:0] mul_signal;
    logic [63:0] mul_product = '0;
    logic [32:0] step_sum;
    int cyc = 0, errors = 0, checks = 0, busy_n = 0, step_n = 0;
    typedef struct { logic [63:0] prod; int acc; } exp_t;
    exp_t sb[$];

    mult_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .mul_reset(mul_reset),
        .mul_signal(mul_signal), .mul_data_a(mul_data_a), .mul_data_b(mul_data_b),
        .mul_product(mul_product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Classic right-shift multiplier: product starts as {0, B}, adds A to the top half when bit0 is set.
    assign step_sum = {1'b0, mul_product[63:32]} + (mul_product[0] ? {1'b0, mul_data_a} : 33'd0);
    always @(posedge clk) begin
        if (mul_reset)
            mul_product <= {32'd0, mul_data_b};
        else if (mul_signal == OP_MULTU)
            mul_product <= {step_sum, mul_product[31:1]};
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            busy_n = 0;
            step_n = 0;
        end else begin
            if (mul_signal == OP_MULTU) step_n++;
            if (busy) busy_n++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", {hi, lo}, e.prod);
                    check("latency", 64'(cyc - e.acc), 64'd34);
                    check("multu_steps", 64'(step_n), 64'd32);
                    check("busy_cycles", 64'(busy_n), 64'd34);
                end
                busy_n = 0;
                step_n = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        start = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        sb.push_back('{exp, cyc});
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc0;
        repeat (3) @(negedge clk);
        check("mul_reset_in_reset", {63'd0, mul_reset}, 64'd1);
        reset = 1'b1;
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("idle_mul_reset", {63'd0, mul_reset}, 64'd0);
        check("idle_signal", {58'd0, mul_signal}, {58'd0, OP_NOP});

        issue(32'd3, 32'd5, 64'd15);
        drain();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        drain();

        // Abort mid-RUN: the pending expectation is withdrawn, any done afterwards is an error.
        issue(32'd11, 32'd13, 64'd143);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mul_reset_abort", {63'd0, mul_reset}, 64'd1);
        repeat (2) @(negedge clk);
        check("mul_reset_abort2", {63'd0, mul_reset}, 64'd1);
        sb.delete();
        reset = 1'b1;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_mul_reset", {63'd0, mul_reset}, 64'd0);
        repeat (50) @(negedge clk);

        // start held high: second request is taken in the done cycle, 35 edges after the first.
        @(negedge clk);
        start = 1'b1; op_a = 32'd7; op_b = 32'd9;
        @(posedge clk); #1;
        acc0 = cyc;
        sb.push_back('{64'd63, acc0});
        sb.push_back('{64'h1_00000000, acc0 + 35});
        repeat (10) @(negedge clk);
        op_a = 32'd2; op_b = 32'h80000000;
        while (cyc < acc0 + 37) @(negedge clk);
        op_a = 32'hDEAD; op_b = 32'hBEEF;
        repeat (5) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        issue(32'h12345678, 32'd0, 64'd0);
        drain();
        issue(32'd0, 32'hFFFFFFFF, 64'd0);
        drain();
        issue(32'd10, 32'd6, 64'd60);
        drain();
        repeat (5) @(negedge clk);
        check("final_queue", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
